// File: rtl/nlm_pkg.sv
// Shared definitions for the NLM line-SRAM read streamer: FSM states and buffer sizing.
package nlm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned FIFO_CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ISSUE_THRESH = 2;

endpackage

// File: rtl/nlm_stream_fifo.sv
// Small synchronous FIFO holding captured SRAM beats; head is presented combinationally.
import nlm_pkg::*;

module nlm_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_pop,
  output logic [DATA_WIDTH-1:0]        o_head,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/nlm_sram_rd_stream.sv
// Turns a (base, len) request into SRAM read strobes and streams the returned data with credit-based flow control.
import nlm_pkg::*;

module nlm_sram_rd_stream #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  rden_o,
  output logic [ADDR_WIDTH-1:0] rdaddr_o,
  input  logic [DATA_WIDTH-1:0] rddata_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_len;
  logic [CW-1:0]         r_iss;
  logic [CW-1:0]         r_pop;
  logic                  r_rden_q;

  logic [FIFO_CNT_W-1:0] w_cnt;
  logic [FIFO_CNT_W:0]   w_occ;
  logic                  w_rden;
  logic                  w_pop;
  logic                  w_last;

  nlm_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rden_q),
    .i_data  (rddata_i),
    .i_pop   (w_pop),
    .o_head  (dout_o),
    .o_count (w_cnt)
  );

  // Entries held plus the read still inside the SRAM; issuing is gated on this credit count.
  assign w_occ        = {1'b0, w_cnt} + {{FIFO_CNT_W{1'b0}}, r_rden_q};
  assign w_rden       = (r_state == ST_RUN) && (r_iss != r_len) &&
                        (w_occ <= (FIFO_CNT_W+1)'(ISSUE_THRESH));
  assign dout_valid_o = (w_cnt != '0);
  assign w_pop        = dout_valid_o & dout_ready_i;
  // Pops never outrun pushes, so reaching len pops implies the buffer drains this cycle;
  // leaving RUN on the final pop puts done_o one cycle after the last beat.
  assign w_last       = ((r_pop + CW'(w_pop)) == r_len);

  assign rden_o   = w_rden;
  assign rdaddr_o = r_base + r_iss[ADDR_WIDTH-1:0];
  assign busy_o   = (r_state == ST_RUN);
  assign done_o   = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_iss    <= '0;
      r_pop    <= '0;
      r_rden_q <= 1'b0;
    end else begin
      r_rden_q <= w_rden;
      if (w_rden) r_iss <= r_iss + 1'b1;
      if (w_pop)  r_pop <= r_pop + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_base  <= base_addr_i;
            r_len   <= len_i;
            r_iss   <= '0;
            r_pop   <= '0;
            r_state <= (len_i == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_last) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nlm_sram_rd_stream.sv
// Randomized bench for nlm_sram_rd_stream against a transaction-level model of the read stream.
module tb_nlm_sram_rd_stream;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   len_i = '0;
  logic          rden_o;
  logic [AW-1:0] rdaddr_o;
  logic [DW-1:0] rddata_i = '0;
  logic [DW-1:0] dout_o;
  logic          dout_valid_o;
  logic          dout_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;
  int issue_cyc [$];

  always #5 clk = ~clk;

  // SRAM model: registered read, junk on the bus when not reading.
  always @(posedge clk) begin
    if (rden_o) rddata_i <= mem[rdaddr_o];
    else        rddata_i <= DW'($urandom);
  end

  nlm_sram_rd_stream #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .rden_o       (rden_o),
    .rdaddr_o     (rdaddr_o),
    .rddata_i     (rddata_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rden"},  32'(rden_o), 0);
    check({tag, "_busy"},  32'(busy_o), 0);
    check({tag, "_done"},  32'(done_o), 0);
    check({tag, "_valid"}, 32'(dout_valid_o), 0);
  endtask

  // mode 0: ready held high; mode 1: random ready; mode 2: random plus a 10-cycle stall from stall_at.
  task automatic run_req(input int base, input int len, input int mode, input int stall_at,
                         input int restart_at, input int max_cyc);
    int  issued, popped, landed, done_cyc;
    bit  finished, exp_busy, exp_done, exp_valid, exp_rden;
    issued = 0; popped = 0; landed = 0; done_cyc = -1; finished = 0;
    issue_cyc.delete();
    @(posedge clk); #1;
    start_i      = 1'b1;
    base_addr_i  = AW'(base);
    len_i        = (AW+1)'(len);
    dout_ready_i = 1'b1;
    for (int cyc = 1; cyc <= max_cyc && !finished; cyc++) begin
      @(posedge clk); #1;
      start_i = (cyc == restart_at);
      if (start_i) begin
        base_addr_i = AW'($urandom);
        len_i       = (AW+1)'($urandom_range(1, 20));
      end
      if (mode == 0)      dout_ready_i = 1'b1;
      else if (mode == 2 && cyc >= stall_at && cyc < stall_at + 10) dout_ready_i = 1'b0;
      else                dout_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      // A read issued in cycle c is presentable from cycle c+2.
      while (issue_cyc.size() > 0 && issue_cyc[0] <= cyc - 2) begin
        void'(issue_cyc.pop_front());
        landed++;
      end
      exp_busy  = (popped < len);
      exp_done  = (popped == len);
      exp_valid = (landed > popped);
      exp_rden  = exp_busy && (issued < len) && (issued - popped <= 2);
      check("busy",  32'(busy_o), 32'(exp_busy));
      check("done",  32'(done_o), 32'(exp_done));
      check("valid", 32'(dout_valid_o), 32'(exp_valid));
      check("rden",  32'(rden_o), 32'(exp_rden));
      if (exp_rden)  check("rdaddr", 32'(rdaddr_o), (base + issued) % DEPTH);
      if (exp_valid) check("dout", 32'(dout_o), 32'(mem[(base + popped) % DEPTH]));
      if (exp_rden) begin
        issue_cyc.push_back(cyc);
        issued++;
      end
      if (exp_valid && dout_ready_i) popped++;
      if (exp_done) begin
        finished = 1'b1;
        done_cyc = cyc;
      end
    end
    start_i = 1'b0;
    check("req_completes", 32'(finished), 1);
    if (mode == 0) check("done_cycle", done_cyc, (len == 0) ? 1 : len + 3);
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("post_done");
  endtask

  task automatic reset_mid_request();
    @(posedge clk); #1;
    start_i      = 1'b1;
    base_addr_i  = AW'($urandom);
    len_i        = (AW+1)'(8);
    dout_ready_i = 1'b1;
    for (int cyc = 1; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    check("pre_reset_busy", 32'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_rdaddr", 32'(rdaddr_o), 0);
    check("async_rst_dout",   32'(dout_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle_outputs("after_rst");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    #12;
    check_idle_outputs("reset");
    check("reset_rdaddr", 32'(rdaddr_o), 0);
    check("reset_dout",   32'(dout_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_req(12'h010, 4, 0, 0, 0, 40);
    run_req(12'hFFE, 4, 0, 0, 0, 40);
    run_req(int'($urandom_range(0, DEPTH-1)), 16, 2, 6, 0, 300);
    run_req(int'($urandom_range(0, DEPTH-1)), 0, 0, 0, 0, 20);
    run_req(int'($urandom_range(0, DEPTH-1)), 8, 0, 0, 2, 60);
    reset_mid_request();
    run_req(12'h800, 4096, 0, 0, 0, 4200);
    for (int r = 0; r < 6; r++)
      run_req(int'($urandom_range(0, DEPTH-1)), int'($urandom_range(1, 40)), 1 + (r % 2),
              int'($urandom_range(2, 10)), 0, 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
